// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared types and constants for the Sobel window compute slice.
//   state_t : FSM encoding (IDLE, GRAD, MAG, OUT)
//   win3_t  : 3x3 neighbourhood, [row][col][pixel]; row 2 = top, col 0 = left
//   abs_grad: magnitude of a signed gradient as an unsigned value
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam int MAG_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GRAD = 2'd1,
        ST_MAG  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    typedef logic [2:0][2:0][PIX_W-1:0] win3_t;

    // Gradients never reach -1024, so the two's-complement negation fits.
    function automatic logic [MAG_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        logic [MAG_W-1:0] u;
        u = g;
        return g[GRAD_W-1] ? (~u + 11'd1) : u;
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// -----------------------------------------------------------------------------
// sobel_kernel
// Combinational 3x3 Sobel operator.
//   win_i : 3x3 window, [row][col]; rows 2/1/0 = top/middle/bottom,
//           cols 0/1/2 = left/centre/right
//   gx_o  : signed horizontal gradient, range +/-1020
//   gy_o  : signed vertical gradient,   range +/-1020
// -----------------------------------------------------------------------------
module sobel_kernel
    import sobel_pkg::*;
(
    input  win3_t                     win_i,
    output logic signed [GRAD_W-1:0]  gx_o,
    output logic signed [GRAD_W-1:0]  gy_o
);

    logic [GRAD_W-1:0] gx_pos_s;
    logic [GRAD_W-1:0] gx_neg_s;
    logic [GRAD_W-1:0] gy_pos_s;
    logic [GRAD_W-1:0] gy_neg_s;

    // Weighted column/row sums; each is at most 4*255 so zero-extension is enough.
    always_comb begin
        gx_pos_s = GRAD_W'(win_i[2][2]) + (GRAD_W'(win_i[1][2]) << 1) + GRAD_W'(win_i[0][2]);
        gx_neg_s = GRAD_W'(win_i[2][0]) + (GRAD_W'(win_i[1][0]) << 1) + GRAD_W'(win_i[0][0]);
        gy_pos_s = GRAD_W'(win_i[0][0]) + (GRAD_W'(win_i[0][1]) << 1) + GRAD_W'(win_i[0][2]);
        gy_neg_s = GRAD_W'(win_i[2][0]) + (GRAD_W'(win_i[2][1]) << 1) + GRAD_W'(win_i[2][2]);
    end

    assign gx_o = $signed(gx_pos_s - gx_neg_s);
    assign gy_o = $signed(gy_pos_s - gy_neg_s);

endmodule

// File: rtl/sobel_window_compute.sv
// -----------------------------------------------------------------------------
// sobel_window_compute
// Picks the 3x3 neighbourhood around `column` out of a 3x8 window, runs the
// Sobel kernel and emits one gradient-magnitude pixel per window.
//   clk, n_rst     : clock, asynchronous active-low reset
//   compute_sobel  : window valid strobe (only looked at in IDLE)
//   window_buffer  : [row][col][pixel], row 2 top, col 0 left
//   column         : centre column, neighbours clamped to [0,7]
//   get_matrix     : high while IDLE (ready for a window)
//   pixel_out      : result pixel, held while pixel_valid & !pixel_ready
//   pixel_valid    : result valid until accepted
//   pixel_ready    : downstream accept
//   edge_detected  : sticky, set when the last pixel of a row is accepted,
//                    cleared by the next accepted window
// Build option: define SOBEL_THRESHOLD_EN to binarise against THRESHOLD
// instead of saturating the magnitude to 255.
// -----------------------------------------------------------------------------
module sobel_window_compute
    import sobel_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = 640,
    parameter logic [7:0]  THRESHOLD = 8'd100
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  compute_sobel,
    input  logic [2:0][7:0][7:0]  window_buffer,
    input  logic [2:0]            column,
    output logic                  get_matrix,
    output logic [PIX_W-1:0]      pixel_out,
    output logic                  pixel_valid,
    input  logic                  pixel_ready,
    output logic                  edge_detected
);

    localparam int CNT_W = ($clog2(IMG_WIDTH) > 10) ? $clog2(IMG_WIDTH) : 10;

    state_t                    state_q, state_d;
    win3_t                     win_q;
    win3_t                     win_sel_s;
    logic signed [GRAD_W-1:0]  gx_q, gy_q;
    logic signed [GRAD_W-1:0]  gx_s, gy_s;
    logic [MAG_W-1:0]          mag_s;
    logic [PIX_W-1:0]          pix_res_s;
    logic [PIX_W-1:0]          pixel_out_q;
    logic                      pixel_valid_q;
    logic                      edge_q;
    logic [CNT_W-1:0]          col_cnt_q;
    logic [2:0]                lcol_s, rcol_s;
    logic                      start_s, accept_s, row_end_s;

    assign start_s   = (state_q == ST_IDLE) && compute_sobel;
    assign accept_s  = pixel_valid_q && pixel_ready;
    assign row_end_s = accept_s && (col_cnt_q == CNT_W'(IMG_WIDTH - 1));

    // Neighbour columns saturate at the window edges rather than wrapping.
    always_comb begin
        lcol_s = (column == 3'd0) ? 3'd0 : column - 3'd1;
        rcol_s = (column == 3'd7) ? 3'd7 : column + 3'd1;
        for (int r = 0; r < 3; r++) begin
            win_sel_s[r][0] = window_buffer[r][lcol_s];
            win_sel_s[r][1] = window_buffer[r][column];
            win_sel_s[r][2] = window_buffer[r][rcol_s];
        end
    end

    sobel_kernel u_kernel (
        .win_i (win_q),
        .gx_o  (gx_s),
        .gy_o  (gy_s)
    );

    // Magnitude and final pixel mapping.
    always_comb begin
        mag_s = abs_grad(gx_q) + abs_grad(gy_q);
`ifdef SOBEL_THRESHOLD_EN
        pix_res_s = (mag_s >= MAG_W'(THRESHOLD)) ? 8'hFF : 8'h00;
`else
        pix_res_s = (mag_s > MAG_W'(255)) ? 8'hFF : mag_s[PIX_W-1:0];
`endif
    end

`ifndef SOBEL_THRESHOLD_EN
    logic unused_threshold_s;
    assign unused_threshold_s = ^THRESHOLD;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (compute_sobel) begin
                    state_d = ST_GRAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRAD: state_d = ST_MAG;
            ST_MAG:  state_d = ST_OUT;
            ST_OUT: begin
                if (pixel_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath pipeline: capture, gradients, output pixel and valid.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            win_q         <= '0;
            gx_q          <= '0;
            gy_q          <= '0;
            pixel_out_q   <= 8'd0;
            pixel_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (compute_sobel) begin
                        win_q <= win_sel_s;
                    end
                end
                ST_GRAD: begin
                    gx_q <= gx_s;
                    gy_q <= gy_s;
                end
                ST_MAG: begin
                    pixel_out_q   <= pix_res_s;
                    pixel_valid_q <= 1'b1;
                end
                ST_OUT: begin
                    if (pixel_ready) begin
                        pixel_valid_q <= 1'b0;
                    end
                end
                default: pixel_valid_q <= 1'b0;
            endcase
        end
    end

    // Row position counter and sticky end-of-row flag (set wins over clear).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_cnt_q <= {CNT_W{1'b0}};
            edge_q    <= 1'b0;
        end else begin
            if (accept_s) begin
                col_cnt_q <= row_end_s ? {CNT_W{1'b0}} : col_cnt_q + CNT_W'(1);
            end
            if (row_end_s) begin
                edge_q <= 1'b1;
            end else if (start_s) begin
                edge_q <= 1'b0;
            end
        end
    end

    assign get_matrix    = (state_q == ST_IDLE);
    assign pixel_out     = pixel_out_q;
    assign pixel_valid   = pixel_valid_q;
    assign edge_detected = edge_q;

endmodule

// File: tb/tb_sobel_window_compute.sv
// -----------------------------------------------------------------------------
// tb_sobel_window_compute
// Directed bench for sobel_window_compute with IMG_WIDTH = 4. Expected pixels
// come from hand-computed gradient magnitudes, mapped according to whether
// SOBEL_THRESHOLD_EN is defined.
// -----------------------------------------------------------------------------
module tb_sobel_window_compute;

    localparam int IMG_W = 4;

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic                 compute_sobel;
    logic [2:0][7:0][7:0] window_buffer;
    logic [2:0]           column;
    logic                 get_matrix;
    logic [7:0]           pixel_out;
    logic                 pixel_valid;
    logic                 pixel_ready;
    logic                 edge_detected;

    int errors = 0;
    int checks = 0;
    int n_acc  = 0;

    always #5 clk = ~clk;

    sobel_window_compute #(
        .IMG_WIDTH (IMG_W),
        .THRESHOLD (8'd100)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .compute_sobel (compute_sobel),
        .window_buffer (window_buffer),
        .column        (column),
        .get_matrix    (get_matrix),
        .pixel_out     (pixel_out),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .edge_detected (edge_detected)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected pixel for a hand-computed magnitude.
    function automatic logic [7:0] exp_pix(input int mag);
`ifdef SOBEL_THRESHOLD_EN
        return (mag >= 100) ? 8'hFF : 8'h00;
`else
        return (mag > 255) ? 8'd255 : 8'(mag);
`endif
    endfunction

    // Same value down every row; byte i of cols is column i.
    function automatic logic [2:0][7:0][7:0] col_win(input logic [63:0] cols);
        logic [2:0][7:0][7:0] w;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 8; c++)
                w[r][c] = cols[c*8 +: 8];
        return w;
    endfunction

    function automatic logic [2:0][7:0][7:0] row_win(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
        logic [2:0][7:0][7:0] w;
        for (int c = 0; c < 8; c++) begin
            w[2][c] = t;
            w[1][c] = m;
            w[0][c] = b;
        end
        return w;
    endfunction

    // Runs one window from a falling edge in IDLE to the falling edge after accept.
    task automatic do_window(input logic [2:0][7:0][7:0] w, input logic [2:0] col,
                             input int mag, input int stall, input string tag);
        logic [7:0] exp;
        exp = exp_pix(mag);
        check_val({tag, "_gm_idle"}, 32'(get_matrix), 32'd1);
        window_buffer = w;
        column        = col;
        compute_sobel = 1'b1;
        pixel_ready   = (stall == 0);
        @(negedge clk);
        compute_sobel = 1'b0;
        window_buffer = ~w;
        column        = col + 3'd3;
        check_val({tag, "_gm_grad"}, 32'(get_matrix), 32'd0);
        check_val({tag, "_vld_grad"}, 32'(pixel_valid), 32'd0);
        check_val({tag, "_edge_clr"}, 32'(edge_detected), 32'd0);
        @(negedge clk);
        check_val({tag, "_vld_mag"}, 32'(pixel_valid), 32'd0);
        check_val({tag, "_gm_mag"}, 32'(get_matrix), 32'd0);
        @(negedge clk);
        check_val({tag, "_vld_out"}, 32'(pixel_valid), 32'd1);
        check_val({tag, "_pix"}, 32'(pixel_out), 32'(exp));
        for (int i = 0; i < stall; i++) begin
            compute_sobel = (i == 2);
            window_buffer = col_win({8{8'd77}});
            @(negedge clk);
            compute_sobel = 1'b0;
            check_val({tag, "_stall_vld"}, 32'(pixel_valid), 32'd1);
            check_val({tag, "_stall_pix"}, 32'(pixel_out), 32'(exp));
            check_val({tag, "_stall_gm"}, 32'(get_matrix), 32'd0);
        end
        pixel_ready = 1'b1;
        @(negedge clk);
        n_acc++;
        check_val({tag, "_vld_acc"}, 32'(pixel_valid), 32'd0);
        check_val({tag, "_gm_acc"}, 32'(get_matrix), 32'd1);
        check_val({tag, "_edge"}, 32'(edge_detected), 32'((n_acc % IMG_W) == 0));
        if (stall > 0) begin
            // The window pulsed during the stall must not have been queued.
            repeat (3) @(negedge clk);
            check_val({tag, "_no_queue_vld"}, 32'(pixel_valid), 32'd0);
            check_val({tag, "_no_queue_gm"}, 32'(get_matrix), 32'd1);
        end
    endtask

    logic [2:0][7:0][7:0] w_tmp;

    initial begin
        n_rst         = 1'b0;
        compute_sobel = 1'b0;
        window_buffer = '0;
        column        = 3'd0;
        pixel_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_gm", 32'(get_matrix), 32'd1);
        check_val("rst_vld", 32'(pixel_valid), 32'd0);
        check_val("rst_pix", 32'(pixel_out), 32'd0);
        check_val("rst_edge", 32'(edge_detected), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);

        do_window(col_win({8{8'd50}}), 3'd3, 0, 0, "flat");
        do_window(col_win({{4{8'd255}}, {4{8'd0}}}), 3'd3, 1020, 0, "vedge");
        do_window(col_win({{7{8'd0}}, 8'd200}), 3'd0, 800, 0, "clamp200");
        do_window(col_win({{7{8'd0}}, 8'd20}), 3'd0, 80, 0, "clamp20");
        do_window(row_win(8'd0, 8'd0, 8'd30), 3'd5, 120, 0, "hedge");
        w_tmp = '0;
        w_tmp[2][4] = 8'd10;
        do_window(w_tmp, 3'd3, 20, 0, "diag");
        do_window(col_win({8'd100, {7{8'd0}}}), 3'd7, 400, 0, "clamp_r");
        do_window(col_win({{4{8'd255}}, {4{8'd0}}}), 3'd3, 1020, 5, "bp");
        do_window(row_win(8'd0, 8'd0, 8'd10), 3'd2, 40, 0, "hedge10");

        // Abort in MAG with col_cnt mid-row.
        check_val("pre_rst_pix", 32'(pixel_out), 32'(exp_pix(40)));
        window_buffer = col_win({{4{8'd255}}, {4{8'd0}}});
        column        = 3'd3;
        compute_sobel = 1'b1;
        @(negedge clk);
        compute_sobel = 1'b0;
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_val("abort_gm", 32'(get_matrix), 32'd1);
        check_val("abort_vld", 32'(pixel_valid), 32'd0);
        check_val("abort_pix", 32'(pixel_out), 32'd0);
        check_val("abort_edge", 32'(edge_detected), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        n_acc = 0;
        @(negedge clk);
        check_val("post_rst_vld", 32'(pixel_valid), 32'd0);

        do_window(col_win({8{8'd50}}), 3'd4, 0, 0, "post1");
        do_window(row_win(8'd0, 8'd0, 8'd30), 3'd1, 120, 0, "post2");
        do_window(col_win({{7{8'd0}}, 8'd20}), 3'd0, 80, 0, "post3");
        do_window(col_win({{4{8'd255}}, {4{8'd0}}}), 3'd3, 1020, 0, "post4");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
